// File: rtl/port_tx_ctrl.sv
// Output-port transmit controller. It pops flits from a first-word-fall-through FIFO and holds the
// switch grant for a whole packet. Each flit goes out over a 4-phase req/ack link.
module port_tx_ctrl #(
  parameter int FLIT_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              arb_req,
  input  logic              arb_grant,
  output logic [FLIT_W-1:0] link_data,
  output logic              link_req,
  input  logic              link_ack,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  pkt_cnt
);

  typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, RELEASE, WAIT} state_t;

  state_t      state, next_state;
  logic [1:0]  ftype;
  logic        is_start, is_end, last, orphan;

  // type 01 = head, 11 = single (packet start); 10 = tail, 11 = single (packet end)
  assign ftype    = fifo_rd_data[FLIT_W-1:FLIT_W-2];
  assign is_start = ftype[0];
  assign is_end   = ftype[1];
  assign orphan   = (state == IDLE) && !fifo_empty && !is_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty && is_start) next_state = ARB;
      ARB:     if (arb_grant) next_state = LOAD;
      LOAD:    next_state = SEND;
      SEND:    if (link_ack) next_state = RELEASE;
      RELEASE: if (!link_ack) begin
                 if (last)             next_state = IDLE;
                 else if (!fifo_empty) next_state = LOAD;
                 else                  next_state = WAIT;
               end
      WAIT:    if (!fifo_empty) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = (state == LOAD) || orphan;
    err_pulse  = orphan;
  end

  // Registered outputs are driven from next_state. They then line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_req   <= 1'b0;
      link_req  <= 1'b0;
      link_data <= '0;
      last      <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      arb_req  <= (next_state != IDLE);
      link_req <= (next_state == SEND);
      if (state == LOAD) begin
        link_data <= fifo_rd_data;
        last      <= is_end;
      end
      if (state == RELEASE && !link_ack && last)
        pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_port_tx_ctrl.sv
// Scoreboarded bench for port_tx_ctrl. The same stimulus drives two instances, one with a 16-bit
// counter and one with a 2-bit counter, so counter wrap is seen alongside the normal traffic.
module tb_port_tx_ctrl;
  localparam int FW = 18;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [FW-1:0] fifo_rd_data = '0;
  logic          arb_grant = 1'b0, link_ack = 1'b0;
  logic          fifo_rd_en, arb_req, link_req, err_pulse;
  logic [FW-1:0] link_data;
  logic [15:0]   pkt_cnt;
  logic          fifo_rd_en2, arb_req2, link_req2, err_pulse2;
  logic [FW-1:0] link_data2;
  logic [1:0]    pkt_cnt2;

  always #5 clk = ~clk;

  port_tx_ctrl #(.FLIT_W(FW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .arb_req(arb_req), .arb_grant(arb_grant), .link_data(link_data),
    .link_req(link_req), .link_ack(link_ack), .err_pulse(err_pulse), .pkt_cnt(pkt_cnt));

  port_tx_ctrl #(.FLIT_W(FW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en2), .arb_req(arb_req2), .arb_grant(arb_grant), .link_data(link_data2),
    .link_req(link_req2), .link_ack(link_ack), .err_pulse(err_pulse2), .pkt_cnt(pkt_cnt2));

  int total = 0, bad = 0;
  logic [FW-1:0] fq[$], exp_flit[$], exp_err[$];
  int exp_cnt[$];
  int gnt_dly = 0, ack_dly = 0, hs_cnt = 0, rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic refresh();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fq[0];
  endtask

  // Pushes land just after a rising edge, so a comb pulse they cause spans the next falling edge.
  task automatic push(input logic [FW-1:0] f);
    fq.push_back(f);
    refresh();
  endtask

  task automatic wait_cnt(input int target);
    int n = 0;
    while (pkt_cnt != 16'(target) && n < 400) begin @(negedge clk); n++; end
    chk("pkt_cnt_reach", 32'(pkt_cnt), target);
  endtask

  // FIFO model: a pop strobe seen mid-cycle takes effect at the following rising edge.
  initial begin
    logic pend;
    forever begin
      @(negedge clk); pend = fifo_rd_en;
      @(posedge clk); #1;
      if (pend && fq.size() > 0) begin fq.delete(0); refresh(); end
    end
  end

  // Arbiter: grant after gnt_dly cycles of request, released when the request drops.
  initial begin
    int gcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!arb_req) begin arb_grant = 1'b0; gcnt = 0; end
      else if (!arb_grant) begin
        if (gcnt >= gnt_dly) arb_grant = 1'b1; else gcnt++;
      end
    end
  end

  // Downstream link: ack after ack_dly cycles of req, drop ack once req falls.
  initial begin
    int acnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!link_req) begin link_ack = 1'b0; acnt = 0; end
      else if (!link_ack) begin
        if (acnt >= ack_dly) link_ack = 1'b1; else acnt++;
      end
    end
  end

  // Monitor: compares every presented flit, error and counter step against the queues.
  initial begin
    logic          p_req = 0, p_ack = 0, p_gnt = 0;
    logic [FW-1:0] p_ld = '0;
    logic [15:0]   p_cnt = '0;
    int            e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fifo_rd_en) begin rd_cnt++; chk("rd_en_on_empty", 32'(fifo_empty), 0); end
        if (link_req && !p_req) begin
          hs_cnt++;
          if (exp_flit.size() == 0) begin
            total++; bad++; $display("FAIL unexpected_flit: got %0h want none", link_data);
          end else chk("link_data", 32'(link_data), 32'(exp_flit.pop_front()));
        end
        if ((p_req || p_ack) && link_data !== p_ld) begin
          total++; bad++; $display("FAIL link_data_stable: got %0h want %0h", link_data, p_ld);
        end
        if (err_pulse) begin
          chk("err_with_rd_en", 32'(fifo_rd_en), 1);
          if (exp_err.size() == 0) begin
            total++; bad++; $display("FAIL unexpected_err: got %0h want none", fifo_rd_data);
          end else chk("err_flit", 32'(fifo_rd_data), 32'(exp_err.pop_front()));
        end
        if (pkt_cnt !== p_cnt) begin
          if (exp_cnt.size() == 0) begin
            total++; bad++; $display("FAIL unexpected_cnt: got %0d want none", pkt_cnt);
          end else begin
            e = exp_cnt.pop_front();
            chk("pkt_cnt", 32'(pkt_cnt), e);
            chk("pkt_cnt_w2", 32'(pkt_cnt2), e % 4);
          end
        end
        if (p_gnt && !arb_grant && arb_req) begin
          total++; bad++; $display("FAIL grant_drop: got 0 want 1");
        end
      end
      p_req = link_req; p_ack = link_ack; p_gnt = arb_grant; p_ld = link_data; p_cnt = pkt_cnt;
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int r0, n, base;
    logic flag;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_arb_req", 32'(arb_req), 0);
    chk("rst_link_req", 32'(link_req), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_err", 32'(err_pulse), 0);
    chk("rst_link_data", 32'(link_data), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single flit, grant after 2 cycles, ack after 1
    gnt_dly = 2; ack_dly = 1; r0 = rd_cnt;
    exp_flit.push_back(18'h300AB); exp_cnt.push_back(1);
    @(posedge clk); #2 push(18'h300AB);
    wait_cnt(1);
    @(negedge clk);
    chk("t1_arb_req_drop", 32'(arb_req), 0);
    chk("t1_rd_en_cnt", 32'(rd_cnt - r0), 1);

    // 2: head/body/body/tail, immediate grant and ack
    gnt_dly = 0; ack_dly = 0; r0 = rd_cnt;
    exp_flit.push_back(18'h10001); exp_flit.push_back(18'h00002);
    exp_flit.push_back(18'h00003); exp_flit.push_back(18'h20004);
    exp_cnt.push_back(2);
    @(posedge clk); #2;
    push(18'h10001); push(18'h00002); push(18'h00003); push(18'h20004);
    repeat (3) @(negedge clk);
    chk("t2_link_req_early", 32'(link_req), 0);
    @(negedge clk);
    chk("t2_link_req_latency", 32'(link_req), 1);
    flag = 0; n = 0;
    while (pkt_cnt != 16'd2 && n < 300) begin
      if (!arb_req) flag = 1;
      @(negedge clk); n++;
    end
    chk("t2_done", 32'(pkt_cnt), 2);
    chk("t2_arb_held", 32'(flag), 0);
    chk("t2_rd_en_cnt", 32'(rd_cnt - r0), 4);

    // 3: head+body, starve 10 cycles, then tail
    base = hs_cnt;
    exp_flit.push_back(18'h10010); exp_flit.push_back(18'h00011); exp_flit.push_back(18'h20012);
    exp_cnt.push_back(3);
    @(posedge clk); #2; push(18'h10010); push(18'h00011);
    n = 0;
    while (!(hs_cnt == base + 2 && !link_req && !link_ack) && n < 100) begin @(negedge clk); n++; end
    chk("t3_two_sent", hs_cnt - base, 2);
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (!arb_req || link_req) flag = 1;
    end
    chk("t3_wait_hold", 32'(flag), 0);
    chk("t3_cnt_open", 32'(pkt_cnt), 2);
    @(posedge clk); #2; push(18'h20012);
    wait_cnt(3);

    // 4: orphan body in IDLE, then a normal single
    r0 = rd_cnt;
    exp_err.push_back(18'h00123);
    @(posedge clk); #2; push(18'h00123);
    flag = 0;
    repeat (5) begin @(negedge clk); if (arb_req) flag = 1; end
    chk("t4_no_arb_req", 32'(flag), 0);
    chk("t4_rd_en_cnt", 32'(rd_cnt - r0), 1);
    chk("t4_err_seen", exp_err.size(), 0);
    exp_flit.push_back(18'h30055); exp_cnt.push_back(4);
    @(posedge clk); #2; push(18'h30055);
    wait_cnt(4);

    // 5: async reset while link_req is high
    ack_dly = 30;
    exp_flit.push_back(18'h300AA);
    @(posedge clk); #2; push(18'h300AA);
    n = 0;
    while (!link_req && n < 50) begin @(negedge clk); n++; end
    chk("t5_in_send", 32'(link_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_link_req", 32'(link_req), 0);
    chk("t5_rst_arb_req", 32'(arb_req), 0);
    chk("t5_rst_rd_en", 32'(fifo_rd_en), 0);
    chk("t5_rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("t5_rst_link_data", 32'(link_data), 0);
    fq.delete(); refresh();
    repeat (3) @(negedge clk);
    rst_n = 1'b1; ack_dly = 0;
    repeat (3) @(negedge clk);
    chk("t5_idle_arb_req", 32'(arb_req), 0);
    chk("t5_idle_link_req", 32'(link_req), 0);

    // 6: five singles; 2-bit instance wraps 1,2,3,0,1
    for (int i = 1; i <= 5; i++) begin
      exp_flit.push_back(18'h30000 | 18'(i));
      exp_cnt.push_back(i);
    end
    @(posedge clk); #2;
    for (int i = 1; i <= 5; i++) push(18'h30000 | 18'(i));
    wait_cnt(5);
    chk("t6_cnt_w2_final", 32'(pkt_cnt2), 1);

    repeat (3) @(negedge clk);
    chk("flits_left", exp_flit.size(), 0);
    chk("cnts_left", exp_cnt.size(), 0);
    chk("errs_left", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
